// File: rtl/sprite_arb_pkg.sv
// Shared constants and types for the sprite ROM arbiter.
// Holds the default geometry of the requester set and the sprite ROM, the
// tag/address typedefs used at that default size, and the round-robin
// pointer advance rule shared by both arbitration modes.
package sprite_arb_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_ADDR_W    = 19;
  localparam int DEF_DATA_W    = 4;
  localparam int DEF_ROM_DEPTH = 280;

  typedef logic [DEF_NUM_REQ-1:0] tag_t;
  typedef logic [DEF_ADDR_W-1:0]  addr_t;

  // Pointer lands one past the winner; in priority mode slot 0 is never a
  // round-robin start, so the pointer skips over it.
  function automatic int rr_next(input int idx, input int n, input bit skip0);
    int nx;
    nx = (idx + 1) % n;
    if (skip0 && nx == 0) nx = 1;
    return nx;
  endfunction

endpackage

// File: rtl/sprite_rr_pick.sv
// Combinational round-robin picker: scans req starting at rr_ptr, wrapping
// from NUM_REQ-1 back to 0, and returns the first asserted requester as a
// one-hot grant plus its binary index.
module sprite_rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  // First requester at or after the pointer wins.
  always_comb begin
    int i;
    i   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      i = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any && req[i[PTR_W-1:0]]) begin
        any                = 1'b1;
        gnt[i[PTR_W-1:0]]  = 1'b1;
        idx                = i[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: shares one registered-read sprite ROM among NUM_REQ
// requesters. One grant per cycle, returned data one cycle later, tagged
// with the one-hot grant. Out-of-range addresses still consume the slot but
// read back as 0 with addr_err.
// Build option: SPRITE_ARB_PRIORITY_EN gives requester 0 (player sprite)
// absolute priority; the rest round-robin among 1..NUM_REQ-1.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ROM_DEPTH = DEF_ROM_DEPTH
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      addr_err,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] rr_req;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [PTR_W-1:0]   rr_idx;
  logic               rr_any;
  logic [NUM_REQ-1:0] gnt_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic               err_p0;
  logic [NUM_REQ-1:0] vld_p1;
  logic               err_p1;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < ROM_DEPTH;
  endfunction

`ifdef SPRITE_ARB_PRIORITY_EN
  assign rr_req = {req[NUM_REQ-1:1], 1'b0};
`else
  assign rr_req = req;
`endif

  sprite_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (rr_req),
    .rr_ptr (rr_ptr),
    .gnt    (rr_gnt),
    .idx    (rr_idx),
    .any    (rr_any)
  );

  // ---- stage p0: grant decision, pointer advance, ROM address ----
  // Resolve the winner and next pointer; nothing is granted during reset.
  always_comb begin
    gnt_p0  = '0;
    ptr_nxt = rr_ptr;
    if (Reset_n) begin
`ifdef SPRITE_ARB_PRIORITY_EN
      if (req[0]) begin
        gnt_p0 = NUM_REQ'(1);
      end else if (rr_any) begin
        gnt_p0  = rr_gnt;
        ptr_nxt = PTR_W'(rr_next(int'(rr_idx), NUM_REQ, 1'b1));
      end
`else
      if (rr_any) begin
        gnt_p0  = rr_gnt;
        ptr_nxt = PTR_W'(rr_next(int'(rr_idx), NUM_REQ, 1'b0));
      end
`endif
    end
  end

  // Route the winner's address to the ROM, zeroed when idle or out of range.
  always_comb begin
    addr_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_p0[i]) addr_p0 = req_addr[i*ADDR_W +: ADDR_W];
    end
    err_p0   = (|gnt_p0) && !in_range(addr_p0);
    rom_addr = err_p0 ? '0 : addr_p0;
  end

  assign gnt = gnt_p0;

  // ---- stage p1: return tag and error flag, aligned with ROM output ----
  // Pointer and in-flight tag; async reset drops any pending return.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr <= '0;
      vld_p1 <= '0;
      err_p1 <= 1'b0;
    end else begin
      rr_ptr <= ptr_nxt;
      vld_p1 <= gnt_p0;
      err_p1 <= err_p0;
    end
  end

  assign rd_valid = vld_p1;
  assign addr_err = (|vld_p1) && err_p1;
  assign rd_data  = ((|vld_p1) && !err_p1) ? rom_data : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter with a behavioural ROM and
// arbitration model; grant-cycle checks in the driver, returns checked by a
// separate monitor against a queue of expected responses.
module tb_sprite_rom_arbiter;

  localparam int N     = 4;
  localparam int AW    = 19;
  localparam int DW    = 4;
  localparam int DEPTH = 280;

  logic            Clk;
  logic            Reset_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rd_valid;
  logic [DW-1:0]   rd_data;
  logic            addr_err;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_DEPTH(DEPTH)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .addr_err (addr_err),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  typedef struct {
    int          cyc;
    logic [N-1:0] tag;
    logic [DW-1:0] data;
    logic        err;
  } exp_t;

  exp_t     q[$];
  logic [DW-1:0] mem [DEPTH];
  int       total = 0;
  int       bad   = 0;
  int       cyc   = 0;
  int       mptr  = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
  end

  // Registered-read sprite ROM model.
  always @(posedge Clk) begin
    cyc      <= cyc + 1;
    rom_data <= (32'(rom_addr) < DEPTH) ? mem[rom_addr] : '0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N*AW-1:0] pack(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                           input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    int s;
    s = $urandom_range(0, 9);
    if (s == 0) return AW'($urandom_range(DEPTH, (1 << AW) - 1));
    if (s == 1) return AW'($urandom_range(DEPTH - 1, DEPTH));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  // Reference arbitration: who wins this cycle given the pending set.
  function automatic int model_pick(input logic [N-1:0] r);
    int g;
    g = -1;
`ifdef SPRITE_ARB_PRIORITY_EN
    if (r[0]) return 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mptr + k) % N;
      if (g < 0 && i != 0 && r[i]) g = i;
    end
    if (g > 0) begin
      mptr = (g + 1) % N;
      if (mptr == 0) mptr = 1;
    end
`else
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mptr + k) % N;
      if (g < 0 && r[i]) g = i;
    end
    if (g >= 0) mptr = (g + 1) % N;
`endif
    return g;
  endfunction

  // One cycle of stimulus: drive, check the grant-cycle outputs, queue the return.
  task automatic step(input logic [N-1:0] r, input logic [N*AW-1:0] pa);
    int            g;
    logic [N-1:0]  eg;
    logic [AW-1:0] a;
    logic [AW-1:0] ea;
    exp_t          e;
    @(negedge Clk);
    req      = r;
    req_addr = pa;
    #1;
    g  = model_pick(r);
    eg = '0;
    ea = '0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      a     = pa[g*AW +: AW];
      e.cyc = cyc + 1;
      e.tag = eg;
      e.err = !(32'(a) < DEPTH);
      e.data = e.err ? '0 : mem[a];
      if (!e.err) ea = a;
      q.push_back(e);
    end
    chk("gnt", 32'(gnt), 32'(eg));
    chk("rom_addr", 32'(rom_addr), 32'(ea));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
    chk({tag, "_addr_err"}, 32'(addr_err), 0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
  endtask

  // Return monitor: every rd_valid must match the oldest expected access.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #2;
      if (rd_valid !== '0) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stray_return rd_valid=%b required=none", rd_valid);
        end else begin
          e = q.pop_front();
          chk("ret_cycle", 32'(cyc), 32'(e.cyc));
          chk("rd_valid", 32'(rd_valid), 32'(e.tag));
          chk("rd_data", 32'(rd_data), 32'(e.data));
          chk("addr_err", 32'(addr_err), 32'(e.err));
        end
      end else begin
        chk("addr_err_idle", 32'(addr_err), 0);
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          total++;
          bad++;
          $display("FAIL missing_return rd_valid=0 required=%b", e.tag);
        end
      end
    end
  end

  initial begin
    Reset_n  = 1'b0;
    req      = '1;
    req_addr = pack(19'd1, 19'd2, 19'd3, 19'd4);
    repeat (3) @(negedge Clk);
    #1;
    reset_checks("reset");
    req     = '0;
    Reset_n = 1'b1;
    mptr    = 0;

    // Single requester after release, address 5.
    step(4'b0001, pack(19'd5, 19'd0, 19'd0, 19'd0));
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("first_rom_addr", 32'(rom_addr), 5);

    // Out-of-range address on requester 2.
    step(4'b0100, pack(19'd0, 19'd0, 19'd280, 19'd0));
    chk("oor_rom_addr", 32'(rom_addr), 0);
    chk("oor_gnt", 32'(gnt), 32'h4);

    // Lone requester 2 with pointer at 3 is still granted; pointer stays 3.
    step(4'b0100, pack(19'd0, 19'd0, 19'd17, 19'd0));
    chk("lone_gnt", 32'(gnt), 32'h4);
    step(4'b1111, pack(19'd10, 19'd11, 19'd12, 19'd13));
`ifndef SPRITE_ARB_PRIORITY_EN
    chk("ptr_after_lone", 32'(gnt), 32'h8);
`endif

    // All four held: round-robin order.
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, pack(rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr()));
`ifndef SPRITE_ARB_PRIORITY_EN
      chk("rr_order", 32'(gnt), 32'(1) << (k % 4));
`endif
    end

`ifdef SPRITE_ARB_PRIORITY_EN
    for (int k = 0; k < 4; k++) begin
      step(4'b1011, pack(rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr()));
      chk("prio_player", 32'(gnt), 32'h1);
    end
    for (int k = 0; k < 4; k++) begin
      step(4'b1010, pack(rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr()));
    end
`endif

    // Reset in the cycle after a grant kills the return.
    step(4'b0010, pack(19'd0, 19'd33, 19'd0, 19'd0));
    @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    q.delete();
    #1;
    reset_checks("midreset");
    repeat (2) @(negedge Clk);
    req     = '0;
    Reset_n = 1'b1;
    mptr    = 0;
    step(4'b1111, pack(19'd40, 19'd41, 19'd42, 19'd43));
    chk("post_reset_gnt", 32'(gnt), 32'h1);

    // Random traffic, including withdrawals and out-of-range addresses.
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] r;
      r = N'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) r = N'(1) << $urandom_range(0, N - 1);
      step(r, pack(rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr()));
    end

    for (int k = 0; k < 3; k++) step('0, '0);
    chk("queue_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
